gearbox_unpacking: RTL
======================

Name: gearbox_unpacking

Overview:
- Downstream neighbour of the n-byte packing gearbox: consumes its nb-bit AXI-Stream words and serializes them into a 1-byte AXI-Stream for byte-oriented consumers (CRC, UART/SPI framers).
- Walks lanes LSB-first, skips lanes whose tkeep bit is 0, and forwards packet boundaries.
- Single holding register plus lane mask; sustains 1 byte/cycle with no bubble between consecutive words.

Parameters:
n, 5, number of byte lanes in the input word (n >= 2)
nb, n*8, input data width in bits (derived; do not override)

Ports:
aclk  input  1  clock, all logic on rising edge
aresetn  input  1  asynchronous active-low reset
in_tdata  input  nb  input word, lane k = bits [8k+7:8k]
in_tkeep  input  n  lane-valid mask; any pattern allowed, including sparse
in_tlast  input  1  last word of packet
in_tvalid  input  1  input word valid
in_tready  output  1  input word accepted when in_tvalid & in_tready
out_tdata  output  8  output byte
out_tlast  output  1  last byte of packet
out_tvalid  output  1  output byte valid
out_tready  input  1  downstream ready
err_empty_last  output  1  one-cycle pulse: a tlast word with tkeep == 0 was accepted

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (aresetn, asserted low clears immediately, independent of aclk).
- Reset values: buf_data = 0, buf_keep = 0, buf_last = 0, err_empty_last = 0; therefore out_tvalid = 0, out_tlast = 0, out_tdata = 0.
- State: buf_data[nb], buf_keep[n] (remaining lanes), buf_last.
- out_tvalid = |buf_keep. If buf_keep == 0, out_tdata = 0.
- sel = index of the lowest set bit of buf_keep; out_tdata = buf_data lane sel.
- out_tlast = buf_last & (buf_keep has exactly one bit set).
- Output byte fires on out_tvalid & out_tready; that cycle clears bit sel of buf_keep.
- in_tready = (buf_keep == 0) | (out_tready & buf_keep has exactly one bit set). This is combinational from out_tready; no in_tvalid -> in_tready path.
- Input accept (in_tvalid & in_tready): buf_data <= in_tdata, buf_keep <= in_tkeep, buf_last <= in_tlast. This overrides the lane clear in the same cycle, so the last byte of word i and the load of word i+1 coincide with zero bubble.
- Latency: the first byte of an accepted word appears on out_tdata the cycle after acceptance.
- Throughput: a word with k kept lanes occupies k output cycles.
- Zero-keep words: accepted in one cycle and emit no bytes.
  - If such a word also has in_tlast = 1, err_empty_last pulses high for the cycle after acceptance.
  - The packet boundary is lost; no out_tlast is generated for it.
- Backpressure: while out_tvalid = 1 and out_tready = 0, out_tdata, out_tlast and out_tvalid hold stable (AXI-S rule), and in_tready = 0.
- in_tvalid low: no state change except byte consumption.
- Reset mid-word: remaining lanes are discarded; there is no partial output after reset release.
- Counters/arithmetic: none beyond the priority encoder and the single-bit test (buf_keep & (buf_keep-1)) == 0.
- No combinational path from in_tdata to out_tdata.

Test Plan:
- Single full word, n=5: in_tdata=0x4443424140, keep=5'b11111, last=1, out_tready=1 -> out bytes 40,41,42,43,44 on 5 consecutive cycles; out_tlast only on 44; in_tready high again on the cycle 44 is presented.
- Sparse keep: data=0x4443424140, keep=5'b10101, last=0 -> bytes 40,42,44; out_tlast=0 throughout.
- Back-to-back: two full words, in_tvalid held high, out_tready=1 -> 10 bytes with out_tvalid continuously high; second word accepted on the same cycle byte 44 fires.
- Backpressure: drop out_tready for 3 cycles mid-word -> out_tdata/out_tvalid/out_tlast stable and in_tready=0 for those cycles; byte sequence unchanged afterwards.
- Zero keep: keep=0, last=1 -> accepted immediately; no output byte; err_empty_last pulses exactly 1 cycle. Same with last=0 -> no pulse.
- Async reset: assert aresetn=0 mid-word between clock edges -> out_tvalid drops without waiting for an edge; after release, in_tready=1 and the next word starts cleanly at lane 0.

Source files
------------

// File: rtl/gearbox_unpacking_if.sv
// gearbox_unpacking_if
//   Bus bundle for the n-byte to 1-byte unpacking gearbox.
//   Input stream : in_tdata[n*8], in_tkeep[n], in_tlast, in_tvalid, in_tready
//   Output stream: out_tdata[8], out_tlast, out_tvalid, out_tready
//   Status       : err_empty_last (pulse on accepted empty tlast word)
//   master = upstream/downstream environment, slave = gearbox.
interface gearbox_unpacking_if #(
    parameter int n = 5
);
    localparam int nb = n * 8;

    logic [nb-1:0] in_tdata;
    logic [n-1:0]  in_tkeep;
    logic          in_tlast;
    logic          in_tvalid;
    logic          in_tready;
    logic [7:0]    out_tdata;
    logic          out_tlast;
    logic          out_tvalid;
    logic          out_tready;
    logic          err_empty_last;

    modport master (
        output in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tlast, out_tvalid, err_empty_last
    );

    modport slave (
        input  in_tdata, in_tkeep, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tlast, out_tvalid, err_empty_last
    );
endinterface

// File: rtl/gearbox_unpacking.sv
// gearbox_unpacking
//   Serializes n-byte AXI-Stream words into a 1-byte AXI-Stream. Lanes are
//   walked LSB-first, lanes with tkeep = 0 are skipped, and tlast is moved to
//   the last kept byte of the word. One word is held at a time; the next word
//   loads on the same cycle the last byte of the current one is taken, so the
//   output sustains one byte per cycle.
//   Ports:
//     aclk    - clock, rising edge
//     aresetn - asynchronous active-low reset
//     bus     - gearbox_unpacking_if.slave (input word stream, output byte
//               stream, err_empty_last pulse)
module gearbox_unpacking #(
    parameter int n = 5
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    gearbox_unpacking_if.slave   bus
);
    localparam int nb = n * 8;

    logic [nb-1:0] r_data;
    logic [n-1:0]  r_keep;   // lanes still to be emitted
    logic          r_last;
    logic          r_err;

    logic [n-1:0]  w_keep_rest;
    logic          w_empty;
    logic          w_one;
    logic          w_fire;
    logic          w_accept;
    logic [7:0]    w_byte;

    // Clearing the lowest set bit gives both the post-fire lane mask and the
    // single-bit test (nothing left after it means exactly one bit was set).
    assign w_keep_rest = r_keep & (r_keep - n'(1));
    assign w_empty     = (r_keep == '0);
    assign w_one       = !w_empty && (w_keep_rest == '0);
    assign w_fire      = !w_empty && bus.out_tready;

    assign bus.in_tready = w_empty || (bus.out_tready && w_one);
    assign w_accept      = bus.in_tvalid && bus.in_tready;

    // Priority select of the lowest kept lane; scanning downward lets the
    // lowest match overwrite higher ones.
    always_comb begin
        w_byte = '0;
        for (int unsigned k = n; k > 0; k--) begin
            if (r_keep[k-1]) begin
                w_byte = r_data[8*(k-1) +: 8];
            end
        end
    end

    assign bus.out_tdata      = w_byte;
    assign bus.out_tvalid     = !w_empty;
    assign bus.out_tlast      = r_last && w_one;
    assign bus.err_empty_last = r_err;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_data <= '0;
            r_keep <= '0;
            r_last <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_accept && bus.in_tlast && (bus.in_tkeep == '0);
            // A load takes priority over the lane clear: the final byte of the
            // held word fires on the same edge the next word is captured.
            if (w_accept) begin
                r_data <= bus.in_tdata;
                r_keep <= bus.in_tkeep;
                r_last <= bus.in_tlast;
            end else if (w_fire) begin
                r_keep <= w_keep_rest;
            end
        end
    end
endmodule
